// File: rtl/minutes_time_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | minutes_pkg                                                          |
// | Shared state encoding and digit limits for the minute stage.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package minutes_pkg;
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        EDIT_LM = 2'd1,
        EDIT_RM = 2'd2
    } state_t;

    localparam int RM_MAX = 9;
    localparam int LM_MAX = 5;
    localparam int RM_W   = 4;
    localparam int LM_W   = 3;
endpackage
`default_nettype wire

// File: rtl/minutes_time_controller_bcd_digit_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_digit_counter                                                    |
// | Single wrapping digit, 0..MAX; wrap flags the MAX->0 step.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bcd_digit_counter #(
    parameter int MAX = 9,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         en,
    output logic [W-1:0] value,
    output logic         wrap
);
    logic [W-1:0] r_value;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (inc && en) begin
            r_value <= (r_value == W'(MAX)) ? '0 : r_value + W'(1);
        end
    end

    assign value = r_value;
    assign wrap  = inc && (r_value == W'(MAX));
endmodule
`default_nettype wire

// File: rtl/minutes_time_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | minutes_time_controller                                              |
// | Minute digits for time and alarm, run/set-time/set-alarm sequencing. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module minutes_time_controller
    import minutes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            min_tick,
    input  logic            btn_mode,
    input  logic            btn_inc,
    input  logic            alarm_sel,
    output logic [RM_W-1:0] time_rm,
    output logic [LM_W-1:0] time_lm,
    output logic [RM_W-1:0] alarm_rm,
    output logic [LM_W-1:0] alarm_lm,
    output logic            hour_carry,
    output logic            edit_lm,
    output logic            edit_rm,
    output logic            edit_alarm,
    output logic            alarm_match
);
    localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t          r_state;
    state_t          w_nextState;
    logic            r_editAlarm;
    logic            r_hourCarry;
    logic            r_alarmMatch;
    logic            w_isRun;
    logic            w_tickAct;
    logic            w_incPulse;
    logic            w_incLm;
    logic            w_incRm;
    logic            w_timeout;
    logic            w_timeRmWrap;
    logic            w_timeLmWrap;
    logic            w_alarmRmWrap;
    logic            w_alarmLmWrap;
    logic            w_unusedAlarmWrap;
    logic [RM_W-1:0] w_nextRm;
    logic [LM_W-1:0] w_nextLm;

    assign w_isRun    = (r_state == RUN);
    // Ticks keep counting while the alarm is being edited; time edits drop them.
    assign w_tickAct  = min_tick && (w_isRun || r_editAlarm);
    assign w_incPulse = btn_inc && !btn_mode;
    assign w_incLm    = w_incPulse && (r_state == EDIT_LM);
    assign w_incRm    = w_incPulse && (r_state == EDIT_RM);

    bcd_digit_counter #(.MAX(RM_MAX), .W(RM_W)) u_timeRm (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (w_tickAct || (w_incRm && !r_editAlarm)),
        .en   (1'b1),
        .value(time_rm),
        .wrap (w_timeRmWrap)
    );

    bcd_digit_counter #(.MAX(LM_MAX), .W(LM_W)) u_timeLm (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  ((w_tickAct && w_timeRmWrap) || (w_incLm && !r_editAlarm)),
        .en   (1'b1),
        .value(time_lm),
        .wrap (w_timeLmWrap)
    );

    bcd_digit_counter #(.MAX(RM_MAX), .W(RM_W)) u_alarmRm (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (w_incRm),
        .en   (r_editAlarm),
        .value(alarm_rm),
        .wrap (w_alarmRmWrap)
    );

    bcd_digit_counter #(.MAX(LM_MAX), .W(LM_W)) u_alarmLm (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (w_incLm),
        .en   (r_editAlarm),
        .value(alarm_lm),
        .wrap (w_alarmLmWrap)
    );

    assign w_unusedAlarmWrap = w_alarmRmWrap ^ w_alarmLmWrap;

    // Post-tick time, so the match pulse lines up with the new digits.
    assign w_nextRm = w_timeRmWrap ? '0 : time_rm + RM_W'(1);
    assign w_nextLm = !w_timeRmWrap ? time_lm :
                      (time_lm == LM_W'(LM_MAX)) ? '0 : time_lm + LM_W'(1);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            logic [TO_W-1:0] r_toCnt;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_toCnt <= '0;
                end else if ((w_nextState != r_state) || btn_mode || btn_inc) begin
                    r_toCnt <= '0;
                end else if (!w_isRun) begin
                    r_toCnt <= r_toCnt + TO_W'(1);
                end
            end

            // A button in the expiry cycle counts as activity and defers the return.
            assign w_timeout = !w_isRun && (r_toCnt == TO_W'(TIMEOUT_CYCLES))
                               && !btn_mode && !btn_inc;
        end else begin : g_noTimeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (btn_mode) begin
            case (r_state)
                RUN:     w_nextState = EDIT_LM;
                EDIT_LM: w_nextState = EDIT_RM;
                default: w_nextState = RUN;
            endcase
        end else if (w_timeout) begin
            w_nextState = RUN;
        end
    end

    always_comb begin
        edit_lm = (r_state == EDIT_LM);
        edit_rm = (r_state == EDIT_RM);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_editAlarm  <= 1'b0;
            r_hourCarry  <= 1'b0;
            r_alarmMatch <= 1'b0;
        end else begin
            if (w_isRun && btn_mode) begin
                r_editAlarm <= alarm_sel;
            end
            r_hourCarry  <= w_tickAct && w_timeLmWrap;
            r_alarmMatch <= w_tickAct && (w_nextLm == alarm_lm) && (w_nextRm == alarm_rm);
        end
    end

    assign edit_alarm  = r_editAlarm;
    assign hour_carry  = r_hourCarry;
    assign alarm_match = r_alarmMatch;
endmodule
`default_nettype wire

// File: tb/tb_minutes_time_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_minutes_time_controller                                           |
// | Directed and random stimulus against a minutes-as-integer model.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_minutes_time_controller;
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       min_tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       alarm_sel = 1'b0;
    logic [3:0] time_rm;
    logic [2:0] time_lm;
    logic [3:0] alarm_rm;
    logic [2:0] alarm_lm;
    logic       hour_carry;
    logic       edit_lm;
    logic       edit_rm;
    logic       edit_alarm;
    logic       alarm_match;

    int total = 0;
    int bad = 0;
    // Model: time/alarm as minutes 0..59, mode 0=run 1=edit LM 2=edit RM.
    int mTm = 0, mAm = 0, mSt = 0, mEa = 0, mToc = 0, mCarry = 0, mMatch = 0;
    int saved;
    int nMatch;

    minutes_time_controller #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .min_tick   (min_tick),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .alarm_sel  (alarm_sel),
        .time_rm    (time_rm),
        .time_lm    (time_lm),
        .alarm_rm   (alarm_rm),
        .alarm_lm   (alarm_lm),
        .hour_carry (hour_carry),
        .edit_lm    (edit_lm),
        .edit_rm    (edit_rm),
        .edit_alarm (edit_alarm),
        .alarm_match(alarm_match)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int bump(input int v, input bit lm);
        if (lm) return ((v / 10 + 1) % 6) * 10 + v % 10;
        return (v / 10) * 10 + (v % 10 + 1) % 10;
    endfunction

    task automatic modelStep(input bit m, input bit i, input bit t, input bit s, input bit r);
        bit act;
        bit to;
        int nst;
        if (!r) begin
            mTm = 0; mAm = 0; mSt = 0; mEa = 0; mToc = 0; mCarry = 0; mMatch = 0;
            return;
        end
        mCarry = 0;
        mMatch = 0;
        act = t && (mSt == 0 || mEa == 1);
        if (act) begin
            mTm    = (mTm + 1) % 60;
            mCarry = (mTm == 0);
            mMatch = (mTm == mAm);
        end
        if (i && !m && mSt != 0) begin
            if (mEa == 1) mAm = bump(mAm, mSt == 1);
            else          mTm = bump(mTm, mSt == 1);
        end
        to  = (mSt != 0) && (mToc == T) && !m && !i;
        nst = m ? (mSt + 1) % 3 : (to ? 0 : mSt);
        if (mSt == 0 && m) mEa = s;
        if (nst != mSt || m || i) mToc = 0;
        else if (mSt != 0) mToc++;
        mSt = nst;
    endtask

    task automatic step(input bit m, input bit i, input bit t, input bit s, input bit r);
        btn_mode  = m;
        btn_inc   = i;
        min_tick  = t;
        alarm_sel = s;
        rst_n     = r;
        @(posedge clk);
        modelStep(m, i, t, s, r);
        #1;
        chk("time_rm", 32'(time_rm), 32'(mTm % 10));
        chk("time_lm", 32'(time_lm), 32'(mTm / 10));
        chk("alarm_rm", 32'(alarm_rm), 32'(mAm % 10));
        chk("alarm_lm", 32'(alarm_lm), 32'(mAm / 10));
        chk("hour_carry", 32'(hour_carry), 32'(mCarry));
        chk("alarm_match", 32'(alarm_match), 32'(mMatch));
        chk("edit_lm", 32'(edit_lm), 32'(mSt == 1));
        chk("edit_rm", 32'(edit_rm), 32'(mSt == 2));
        chk("edit_alarm", 32'(edit_alarm), 32'(mEa));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 1);
    endtask

    task automatic incs(input int n);
        for (int k = 0; k < n; k++) step(0, 1, 0, 0, 1);
    endtask

    initial begin
        // Reset, including ticks that must be ignored while held.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0);
        chk("rst_time", {time_lm, time_rm}, 32'd0);
        step(0, 0, 0, 0, 1);

        // Preload time 58 via editing, then tick to 59 and 00.
        step(1, 0, 0, 0, 1);
        incs(5);
        step(1, 0, 0, 0, 1);
        incs(8);
        step(1, 0, 0, 0, 1);
        chk("preload_58", 32'(time_lm) * 10 + 32'(time_rm), 32'd58);
        step(0, 0, 1, 0, 1);
        chk("tick_59", 32'(time_lm) * 10 + 32'(time_rm), 32'd59);
        chk("no_carry_59", 32'(hour_carry), 32'd0);
        step(0, 0, 1, 0, 1);
        chk("wrap_00", 32'(time_lm) * 10 + 32'(time_rm), 32'd0);
        chk("carry_at_00", 32'(hour_carry), 32'd1);
        idle(1);
        chk("carry_single", 32'(hour_carry), 32'd0);
        for (int k = 0; k < 9; k++) step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        chk("tick_09_10", 32'(time_lm) * 10 + 32'(time_rm), 32'd10);
        chk("no_carry_10", 32'(hour_carry), 32'd0);

        // Alarm edit: LM=3, RM wraps to 1, then run time to 31.
        step(1, 0, 0, 1, 1);
        incs(3);
        step(1, 0, 0, 0, 1);
        incs(11);
        step(1, 0, 0, 0, 1);
        chk("alarm_31", 32'(alarm_lm) * 10 + 32'(alarm_rm), 32'd31);
        nMatch = 0;
        for (int k = 0; k < 60 && mTm != 31; k++) begin
            step(0, 0, 1, 0, 1);
            nMatch += int'(alarm_match);
        end
        idle(2);
        nMatch += int'(alarm_match);
        chk("alarm_hits", 32'(nMatch), 32'd1);

        // Ticks dropped while editing time, counted while editing alarm.
        saved = mTm;
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 1);
        step(1, 0, 0, 0, 1);
        chk("drop_ticks", 32'(time_lm) * 10 + 32'(time_rm), 32'(saved));
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 1);
        step(1, 0, 0, 0, 1);
        chk("alarm_edit_ticks", 32'(time_lm) * 10 + 32'(time_rm), 32'((saved + 5) % 60));

        // Timeout after T idle cycles, restarted by a btn_inc.
        step(1, 0, 0, 0, 1);
        idle(T);
        chk("to_still_edit", 32'(edit_lm), 32'd1);
        idle(1);
        chk("to_back_run", 32'(edit_lm | edit_rm), 32'd0);
        step(1, 0, 0, 0, 1);
        idle(4);
        step(0, 1, 0, 0, 1);
        idle(T);
        chk("to_restart_edit", 32'(edit_lm), 32'd1);
        idle(1);
        chk("to_restart_run", 32'(edit_lm), 32'd0);

        // Mode and inc together: mode wins, digit unchanged.
        step(1, 0, 0, 0, 1);
        saved = mTm / 10;
        step(1, 1, 0, 0, 1);
        chk("mode_wins_state", 32'(edit_rm), 32'd1);
        chk("mode_wins_digit", 32'(time_lm), 32'(saved));
        step(1, 0, 0, 0, 1);

        // Random traffic, including occasional mid-edit reset.
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 199) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
